// File: rtl/handshake_rx.sv
// Destination side of a four-phase req/ack crossing: synchronizes the request level,
// captures the sender's word, offers it on valid/ready, then returns a level acknowledge.
module handshake_rx #(
  parameter int DW    = 32,
  parameter int NSYNC = 2
) (
  input  logic          i_clk,
  input  logic          i_reset_n,
  input  logic          i_req,
  input  logic [DW-1:0] i_data,
  output logic          o_ack,
  output logic          o_valid,
  input  logic          i_ready,
  output logic [DW-1:0] o_data,
  output logic          o_err
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    HOLD = 2'd1,
    ACK  = 2'd2
  } state_t;

  state_t           state_reg;
  logic [NSYNC-1:0] sync_reg;
  logic             req_s;
  logic             req_d_reg;

  // Request synchronizer; stage 0 is the only flop that samples the foreign level.
  always_ff @(posedge i_clk) begin
    if (!i_reset_n) begin
      sync_reg <= '0;
    end else begin
      sync_reg <= {sync_reg[NSYNC-2:0], i_req};
    end
  end

  assign req_s = sync_reg[NSYNC-1];

  always_ff @(posedge i_clk) begin
    if (!i_reset_n) begin
      state_reg <= IDLE;
      req_d_reg <= 1'b0;
      o_ack     <= 1'b0;
      o_valid   <= 1'b0;
      o_data    <= '0;
      o_err     <= 1'b0;
    end else begin
      req_d_reg <= req_s;
      o_err     <= 1'b0;
      case (state_reg)
        IDLE: begin
          if (req_s) begin
            o_data    <= i_data;
            o_valid   <= 1'b1;
            state_reg <= HOLD;
          end
        end
        HOLD: begin
          // Edge-detected so a request that stays low flags the violation only once.
          if (req_d_reg && !req_s) begin
            o_err <= 1'b1;
          end
          if (i_ready) begin
            o_valid   <= 1'b0;
            o_ack     <= 1'b1;
            state_reg <= ACK;
          end
        end
        ACK: begin
          if (!req_s) begin
            o_ack     <= 1'b0;
            state_reg <= IDLE;
          end
        end
        default: begin
          o_ack     <= 1'b0;
          o_valid   <= 1'b0;
          state_reg <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_handshake_rx.sv
// Directed bench for handshake_rx (DW=32, NSYNC=2): latency, backpressure, a 100-word
// sequence, protocol violation and reset in HOLD / ACK.
module tb_handshake_rx;

  logic        clk;
  logic        reset_n;
  logic        req;
  logic [31:0] data;
  logic        ack;
  logic        valid;
  logic        ready;
  logic [31:0] odata;
  logic        err;

  int checks;
  int errors;
  int err_seen;
  logic [31:0] words[$];

  handshake_rx #(.DW(32), .NSYNC(2)) dut (
    .i_clk    (clk),
    .i_reset_n(reset_n),
    .i_req    (req),
    .i_data   (data),
    .o_ack    (ack),
    .o_valid  (valid),
    .i_ready  (ready),
    .o_data   (odata),
    .o_err    (err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Transfers and error pulses are recorded mid-cycle, away from the active edge.
  always @(negedge clk) begin
    if (reset_n && valid && ready) begin
      words.push_back(odata);
      $display("xfer word=%08h", odata);
    end
    if (reset_n && err) err_seen++;
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic step_rand();
    tick();
    ready = ($urandom_range(0, 1) == 1);
  endtask

  task automatic test_reset();
    reset_n = 1'b0; req = 1'b0; data = 32'hFFFF_FFFF; ready = 1'b1;
    tick(); tick();
    checks++; if (ack !== 1'b0) begin errors++; $display("FAIL reset_ack got=%b exp=0", ack); end
    checks++; if (valid !== 1'b0) begin errors++; $display("FAIL reset_valid got=%b exp=0", valid); end
    checks++; if (odata !== 32'h0) begin errors++; $display("FAIL reset_data got=%08h exp=00000000", odata); end
    checks++; if (err !== 1'b0) begin errors++; $display("FAIL reset_err got=%b exp=0", err); end
    reset_n = 1'b1;
    tick();
    $display("test_reset done");
  endtask

  task automatic test_basic();
    int n0;
    n0 = words.size();
    ready = 1'b1; data = 32'hDEAD_BEEF; req = 1'b1;
    tick(); tick(); // after edge 1
    checks++; if (valid !== 1'b0) begin errors++; $display("FAIL basic_early_valid got=%b exp=0", valid); end
    tick(); // after edge 2
    checks++; if (valid !== 1'b1) begin errors++; $display("FAIL basic_valid got=%b exp=1", valid); end
    checks++; if (odata !== 32'hDEAD_BEEF) begin errors++; $display("FAIL basic_data got=%08h exp=deadbeef", odata); end
    tick(); // after edge 3
    checks++; if (ack !== 1'b1 || valid !== 1'b0) begin errors++; $display("FAIL basic_ack got=%b/%b exp=1/0", ack, valid); end
    req = 1'b0;
    tick(); tick(); // after edge 5
    checks++; if (ack !== 1'b1) begin errors++; $display("FAIL basic_ack_hold got=%b exp=1", ack); end
    tick(); // after edge 6
    checks++; if (ack !== 1'b0) begin errors++; $display("FAIL basic_ack_fall got=%b exp=0", ack); end
    repeat (4) tick();
    checks++; if (words.size() - n0 !== 1) begin errors++; $display("FAIL basic_count got=%0d exp=1", words.size() - n0); end
    $display("test_basic done");
  endtask

  task automatic test_backpressure();
    int n0;
    n0 = words.size();
    ready = 1'b0; data = 32'hDEAD_BEEF; req = 1'b1;
    for (int i = 0; i < 10 && !valid; i++) tick();
    checks++; if (valid !== 1'b1) begin errors++; $display("FAIL bp_valid_timeout got=%b exp=1", valid); end
    data = 32'h0;
    for (int i = 0; i < 10; i++) begin
      tick();
      checks++;
      if (valid !== 1'b1 || odata !== 32'hDEAD_BEEF || ack !== 1'b0) begin
        errors++;
        $display("FAIL bp_hold cyc=%0d got v=%b d=%08h a=%b exp v=1 d=deadbeef a=0", i, valid, odata, ack);
      end
    end
    ready = 1'b1;
    tick();
    checks++; if (ack !== 1'b1 || valid !== 1'b0) begin errors++; $display("FAIL bp_release got=%b/%b exp=1/0", ack, valid); end
    req = 1'b0;
    for (int i = 0; i < 10 && ack; i++) tick();
    checks++; if (ack !== 1'b0) begin errors++; $display("FAIL bp_ack_fall got=%b exp=0", ack); end
    checks++; if (words.size() - n0 !== 1) begin errors++; $display("FAIL bp_count got=%0d exp=1", words.size() - n0); end
    $display("test_backpressure done");
  endtask

  task automatic test_sequence();
    int e0;
    int timeouts;
    words.delete();
    e0 = err_seen;
    timeouts = 0;
    for (int w = 0; w < 100; w++) begin
      data = w;
      req = 1'b1;
      for (int i = 0; i < 200 && !ack; i++) step_rand();
      if (!ack) timeouts++;
      repeat ($urandom_range(0, 3)) step_rand();
      req = 1'b0;
      for (int i = 0; i < 200 && ack; i++) step_rand();
      if (ack) timeouts++;
      repeat ($urandom_range(0, 3)) step_rand();
    end
    ready = 1'b0;
    repeat (4) tick();
    checks++; if (timeouts !== 0) begin errors++; $display("FAIL seq_timeouts got=%0d exp=0", timeouts); end
    checks++; if (words.size() !== 100) begin errors++; $display("FAIL seq_count got=%0d exp=100", words.size()); end
    for (int w = 0; w < 100 && w < words.size(); w++) begin
      checks++;
      if (words[w] !== w) begin errors++; $display("FAIL seq_word idx=%0d got=%08h exp=%08h", w, words[w], w); end
    end
    checks++; if (err_seen !== e0) begin errors++; $display("FAIL seq_err got=%0d exp=%0d", err_seen - e0, 0); end
    $display("test_sequence done");
  endtask

  task automatic test_violation();
    int n0;
    n0 = words.size();
    ready = 1'b0; data = 32'hA5A5_5A5A; req = 1'b1;
    for (int i = 0; i < 10 && !valid; i++) tick();
    checks++; if (valid !== 1'b1) begin errors++; $display("FAIL viol_valid_timeout got=%b exp=1", valid); end
    req = 1'b0; // before edge m
    tick(); tick(); // after m+1
    checks++; if (err !== 1'b0) begin errors++; $display("FAIL viol_err_early got=%b exp=0", err); end
    tick(); // after m+2
    checks++; if (err !== 1'b1) begin errors++; $display("FAIL viol_err_pulse got=%b exp=1", err); end
    tick(); // after m+3
    checks++; if (err !== 1'b0) begin errors++; $display("FAIL viol_err_once got=%b exp=0", err); end
    tick();
    checks++; if (err !== 1'b0 || valid !== 1'b1) begin errors++; $display("FAIL viol_hold got e=%b v=%b exp e=0 v=1", err, valid); end
    ready = 1'b1;
    tick();
    checks++; if (ack !== 1'b1 || valid !== 1'b0) begin errors++; $display("FAIL viol_ack_rise got=%b/%b exp=1/0", ack, valid); end
    tick();
    checks++; if (ack !== 1'b0) begin errors++; $display("FAIL viol_ack_fall got=%b exp=0", ack); end
    repeat (3) tick();
    checks++; if (valid !== 1'b0) begin errors++; $display("FAIL viol_idle got=%b exp=0", valid); end
    checks++;
    if (words.size() - n0 !== 1 || words[words.size()-1] !== 32'hA5A5_5A5A) begin
      errors++;
      $display("FAIL viol_word got n=%0d last=%08h exp n=1 last=a5a55a5a", words.size() - n0, words[words.size()-1]);
    end
    $display("test_violation done");
  endtask

  task automatic test_reset_hold();
    ready = 1'b0; data = 32'h1234_5678; req = 1'b1;
    for (int i = 0; i < 10 && !valid; i++) tick();
    checks++; if (valid !== 1'b1) begin errors++; $display("FAIL rh_valid_timeout got=%b exp=1", valid); end
    reset_n = 1'b0;
    tick();
    checks++; if (valid !== 1'b0 || ack !== 1'b0 || odata !== 32'h0) begin errors++; $display("FAIL rh_reset got v=%b a=%b d=%08h exp 0/0/00000000", valid, ack, odata); end
    reset_n = 1'b1;
    tick(); tick(); // after release edges 0,1
    checks++; if (valid !== 1'b0) begin errors++; $display("FAIL rh_early got=%b exp=0", valid); end
    tick(); // after edge 2
    checks++; if (valid !== 1'b1 || odata !== 32'h1234_5678) begin errors++; $display("FAIL rh_recapture got v=%b d=%08h exp v=1 d=12345678", valid, odata); end
    ready = 1'b1;
    tick();
    req = 1'b0;
    for (int i = 0; i < 10 && ack; i++) tick();
    checks++; if (ack !== 1'b0) begin errors++; $display("FAIL rh_ack_fall got=%b exp=0", ack); end
    $display("test_reset_hold done");
  endtask

  task automatic test_reset_ack();
    int n0;
    ready = 1'b1; data = 32'hCAFE_F00D; req = 1'b1;
    for (int i = 0; i < 10 && !ack; i++) tick();
    checks++; if (ack !== 1'b1) begin errors++; $display("FAIL ra_ack_timeout got=%b exp=1", ack); end
    n0 = words.size();
    req = 1'b0;
    reset_n = 1'b0;
    tick();
    checks++; if (ack !== 1'b0 || valid !== 1'b0 || odata !== 32'h0) begin errors++; $display("FAIL ra_reset got a=%b v=%b d=%08h exp 0/0/00000000", ack, valid, odata); end
    reset_n = 1'b1;
    for (int i = 0; i < 6; i++) begin
      tick();
      checks++;
      if (valid !== 1'b0 || ack !== 1'b0) begin errors++; $display("FAIL ra_idle cyc=%0d got v=%b a=%b exp 0/0", i, valid, ack); end
    end
    checks++; if (words.size() !== n0) begin errors++; $display("FAIL ra_count got=%0d exp=%0d", words.size(), n0); end
    $display("test_reset_ack done");
  endtask

  initial begin
    checks = 0; errors = 0; err_seen = 0;
    reset_n = 1'b0; req = 1'b0; data = '0; ready = 1'b0;
    test_reset();
    test_basic();
    test_backpressure();
    test_sequence();
    test_violation();
    test_reset_hold();
    test_reset_ack();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
